char_row_serializer: RTL and testbench
======================================

// Module: char_row_serializer
// PURPOSE
//  Successor to the 1-bpp glyph-row shifter in the char OSD path. Takes one glyph row of
//  CHAR_PIC_WIDTH pixels of PIX_BITS each (anti-aliased/colour-index glyphs) with its screen
//  origin and emits one pixel per beat with its X/Y coordinate. Adds runtime horizontal scaling,
//  right-edge clipping and a row-last marker. Sits between the glyph ROM reader and the OSD blender.
// PARAMETERS
//  CHAR_PIC_WIDTH  9     pixels per glyph row
//  PIX_BITS        1     bits per pixel; pixel 0 = most-significant PIX_BITS of s_row_pixels_data
//  SCALE_W         3     width of cfg_scale (max scale 2**SCALE_W-1)
//  POS_W           11    coordinate width
//  SCREEN_WIDTH    1920  visible width; valid X = 0..SCREEN_WIDTH-1
//  SCREEN_HEIGHT   1080  visible height; valid Y = 0..SCREEN_HEIGHT-1
// PORTS
//  clk                 in   1                      clock
//  resetn              in   1                      async active-low reset
//  cfg_scale           in   SCALE_W                horizontal repeat per pixel, 0 treated as 1
//  s_row_pixels_data   in   CHAR_PIC_WIDTH*PIX_BITS glyph row
//  s_row_pixels_valid  in   1                      row valid
//  s_row_pixels_posX   in   POS_W                  X of pixel 0
//  s_row_pixels_posY   in   POS_W                  Y of row
//  s_row_pixels_ready  out  1                      row accepted when valid&ready
//  m_pixel_data        out  PIX_BITS               current pixel
//  m_pixel_valid       out  1                      pixel valid
//  m_pixel_ready       in   1                      downstream ready
//  m_pixel_posX        out  POS_W                  pixel X
//  m_pixel_posY        out  POS_W                  pixel Y
//  m_pixel_last        out  1                      final emitted beat of the row
//  busy                out  1                      row in flight or held
// BEHAVIOUR
//  - Reset (async, resetn=0): m_pixel_valid/last/data/posX/posY=0, busy=0, s_row_pixels_ready=0;
//    in-flight and held rows discarded. Ready=1 from first clock after release.
//  - FSM IDLE -> SHIFT on accept of in-range row; SHIFT -> IDLE after last beat handshake with
//    no held row, else SHIFT reloads from held row same cycle.
//  - Accept: cfg_scale latched; first pixel valid the next cycle (latency 1).
//  - Each pixel repeated scale times; posX increments by 1 every beat; posY constant.
//    Beat advances only on m_pixel_valid&m_pixel_ready; data/pos/last stable while stalled.
//  - Out-of-range row (posX>=SCREEN_WIDTH or posY>=SCREEN_HEIGHT): accepted, zero beats,
//    no m_pixel_last.
//  - Right clip: row ends at beat with posX==SCREEN_WIDTH-1 (m_pixel_last=1 there); rest dropped.
//    posX never wraps.
//  - m_pixel_last=1 on beat CHAR_PIC_WIDTH*scale-1 or the clip beat, whichever first.
//  - Counters: pix_cnt clog2(CHAR_PIC_WIDTH), rep_cnt SCALE_W; compare against latched scale-1.
//  - cfg_scale changes mid-row have no effect until next accept.
// CONFIGURATION
//  ROW_PREFETCH_EN defined: one-entry holding register; ready=1 whenever holding reg empty;
//   next row starts on cycle after current last handshake -> zero-bubble back-to-back rows.
//  ROW_PREFETCH_EN undefined: ready=1 only in IDLE (registered); one idle cycle between rows.
// STRUCTURE
//  - Shared header osd_char_defs.vh: SCREEN_WIDTH/HEIGHT, POS_W, CHAR_PIC_WIDTH, PIX_BITS defaults,
//    FSM state encodings (IDLE=0, SHIFT=1).
//  - Sub-module row_hold_reg: valid/ready one-entry register for data+posX+posY+scale,
//    instantiated only under ROW_PREFETCH_EN.
// TESTING
//  1. scale=1, data=9'b101100001 at (100,20), ready=1 -> 9 beats data 1,0,1,1,0,0,0,0,1,
//     posX 100..108, posY 20, last only at 108, first valid 1 cycle after accept.
//  2. same row, scale=3 -> 27 beats, each bit 3x, posX 100..126, last at 126.
//  3. posX=1915, scale=1 -> 5 beats posX 1915..1919, last at 1919, then FSM returns IDLE.
//  4. posY=1080 -> row accepted, m_pixel_valid stays 0, ready=1 next cycle.
//  5. m_pixel_ready random 50%, PIX_BITS=2 -> every beat seen once, in order, held while stalled.
//  6. two rows back-to-back: with ROW_PREFETCH_EN 18 consecutive valid beats; without, one-cycle
//     gap; resetn pulse mid-row -> valid=0 immediately, no residual beats.

Source files
------------

// File: rtl/char_row_serializer_pkg.sv
// rtl/char_row_serializer_pkg.sv - shared OSD char-path defaults and row FSM encoding
package char_row_serializer_pkg;

  localparam int SCREEN_WIDTH_DEF   = 1920;
  localparam int SCREEN_HEIGHT_DEF  = 1080;
  localparam int POS_W_DEF          = 11;
  localparam int CHAR_PIC_WIDTH_DEF = 9;
  localparam int PIX_BITS_DEF       = 1;
  localparam int SCALE_W_DEF        = 3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

endpackage

// File: rtl/char_row_serializer_row_hold_reg.sv
// rtl/char_row_serializer_row_hold_reg.sv - one-entry valid/ready holding register for a glyph row
module char_row_serializer_row_hold_reg #(
  parameter int DW      = 9,
  parameter int POS_W   = 11,
  parameter int SCALE_W = 3
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [DW-1:0]      i_data,
  input  logic [POS_W-1:0]   i_posx,
  input  logic [POS_W-1:0]   i_posy,
  input  logic [SCALE_W-1:0] i_scale,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [DW-1:0]      o_data,
  output logic [POS_W-1:0]   o_posx,
  output logic [POS_W-1:0]   o_posy,
  output logic [SCALE_W-1:0] o_scale
);

  logic r_full;
  logic r_alive;

  // r_alive keeps ready low while reset is asserted and opens it on the first clock after release
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_full  <= 1'b0;
      r_alive <= 1'b0;
      o_data  <= '0;
      o_posx  <= '0;
      o_posy  <= '0;
      o_scale <= '0;
    end else begin
      r_alive <= 1'b1;
      if (i_valid && o_ready) begin
        r_full  <= 1'b1;
        o_data  <= i_data;
        o_posx  <= i_posx;
        o_posy  <= i_posy;
        o_scale <= i_scale;
      end else if (i_ready) begin
        r_full <= 1'b0;
      end
    end
  end

  assign o_ready = r_alive & ~r_full;
  assign o_valid = r_full;

endmodule

// File: rtl/char_row_serializer.sv
// rtl/char_row_serializer.sv - glyph row to scaled, clipped pixel stream with X/Y coordinates
// Optional zero-bubble row prefetch is enabled by defining ROW_PREFETCH_EN.
module char_row_serializer
  import char_row_serializer_pkg::*;
#(
  parameter int CHAR_PIC_WIDTH = CHAR_PIC_WIDTH_DEF,
  parameter int PIX_BITS       = PIX_BITS_DEF,
  parameter int SCALE_W        = SCALE_W_DEF,
  parameter int POS_W          = POS_W_DEF,
  parameter int SCREEN_WIDTH   = SCREEN_WIDTH_DEF,
  parameter int SCREEN_HEIGHT  = SCREEN_HEIGHT_DEF
) (
  input  logic                               clk,
  input  logic                               resetn,
  input  logic [SCALE_W-1:0]                 cfg_scale,
  input  logic [CHAR_PIC_WIDTH*PIX_BITS-1:0] s_row_pixels_data,
  input  logic                               s_row_pixels_valid,
  input  logic [POS_W-1:0]                   s_row_pixels_posX,
  input  logic [POS_W-1:0]                   s_row_pixels_posY,
  output logic                               s_row_pixels_ready,
  output logic [PIX_BITS-1:0]                m_pixel_data,
  output logic                               m_pixel_valid,
  input  logic                               m_pixel_ready,
  output logic [POS_W-1:0]                   m_pixel_posX,
  output logic [POS_W-1:0]                   m_pixel_posY,
  output logic                               m_pixel_last,
  output logic                               busy
);

  localparam int DW = CHAR_PIC_WIDTH * PIX_BITS;
  localparam int CW = (CHAR_PIC_WIDTH > 1) ? $clog2(CHAR_PIC_WIDTH) : 1;
  localparam logic [CW-1:0]    PIX_LAST = CW'(CHAR_PIC_WIDTH - 1);
  localparam logic [POS_W-1:0] X_LIMIT  = POS_W'(SCREEN_WIDTH);
  localparam logic [POS_W-1:0] Y_LIMIT  = POS_W'(SCREEN_HEIGHT);
  localparam logic [POS_W-1:0] X_MAX    = POS_W'(SCREEN_WIDTH - 1);

  state_e             r_state;
  state_e             w_next_state;
  logic [DW-1:0]      r_data;
  logic [POS_W-1:0]   r_posx;
  logic [POS_W-1:0]   r_posy;
  logic [SCALE_W-1:0] r_scale_m1;
  logic [CW-1:0]      r_pix_cnt;
  logic [SCALE_W-1:0] r_rep_cnt;

  logic               w_fire;
  logic               w_last;
  logic               w_slot;
  logic               w_ld_valid;
  logic               w_ld_in_range;
  logic [DW-1:0]      w_ld_data;
  logic [POS_W-1:0]   w_ld_posx;
  logic [POS_W-1:0]   w_ld_posy;
  logic [SCALE_W-1:0] w_ld_scale;

  assign m_pixel_valid = (r_state == ST_SHIFT);
  assign m_pixel_data  = r_data[DW-1 -: PIX_BITS];
  assign m_pixel_posX  = r_posx;
  assign m_pixel_posY  = r_posy;
  // The row ends at its natural final beat or at the right screen edge, whichever comes first
  assign w_last        = m_pixel_valid &
                         (((r_pix_cnt == PIX_LAST) && (r_rep_cnt == r_scale_m1)) || (r_posx == X_MAX));
  assign m_pixel_last  = w_last;
  assign w_fire        = m_pixel_valid & m_pixel_ready;
  assign w_slot        = (r_state == ST_IDLE) | (w_fire & w_last);
  assign w_ld_in_range = (w_ld_posx < X_LIMIT) && (w_ld_posy < Y_LIMIT);

`ifdef ROW_PREFETCH_EN
  logic               w_hold_valid;
  logic               w_hold_in_ready;
  logic               w_take_hold;
  logic               w_take_in;
  logic [DW-1:0]      w_hold_data;
  logic [POS_W-1:0]   w_hold_posx;
  logic [POS_W-1:0]   w_hold_posy;
  logic [SCALE_W-1:0] w_hold_scale;

  // A row arriving while a load slot is open bypasses the holding register
  assign w_take_hold = w_slot & w_hold_valid;
  assign w_take_in   = w_slot & ~w_hold_valid & s_row_pixels_valid & w_hold_in_ready;

  char_row_serializer_row_hold_reg #(
    .DW      (DW),
    .POS_W   (POS_W),
    .SCALE_W (SCALE_W)
  ) u_hold (
    .clk     (clk),
    .resetn  (resetn),
    .i_valid (s_row_pixels_valid & ~w_take_in),
    .o_ready (w_hold_in_ready),
    .i_data  (s_row_pixels_data),
    .i_posx  (s_row_pixels_posX),
    .i_posy  (s_row_pixels_posY),
    .i_scale (cfg_scale),
    .o_valid (w_hold_valid),
    .i_ready (w_take_hold),
    .o_data  (w_hold_data),
    .o_posx  (w_hold_posx),
    .o_posy  (w_hold_posy),
    .o_scale (w_hold_scale)
  );

  assign s_row_pixels_ready = w_hold_in_ready;
  assign w_ld_valid = w_take_hold | w_take_in;
  assign w_ld_data  = w_hold_valid ? w_hold_data  : s_row_pixels_data;
  assign w_ld_posx  = w_hold_valid ? w_hold_posx  : s_row_pixels_posX;
  assign w_ld_posy  = w_hold_valid ? w_hold_posy  : s_row_pixels_posY;
  assign w_ld_scale = w_hold_valid ? w_hold_scale : cfg_scale;
  assign busy       = (r_state == ST_SHIFT) | w_hold_valid;
`else
  logic r_ready;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_ready <= 1'b0;
    else         r_ready <= (w_next_state == ST_IDLE);
  end

  assign s_row_pixels_ready = r_ready;
  assign w_ld_valid = w_slot & s_row_pixels_valid & r_ready;
  assign w_ld_data  = s_row_pixels_data;
  assign w_ld_posx  = s_row_pixels_posX;
  assign w_ld_posy  = s_row_pixels_posY;
  assign w_ld_scale = cfg_scale;
  assign busy       = (r_state == ST_SHIFT);
`endif

  always_comb begin
    w_next_state = r_state;
    if (w_ld_valid)               w_next_state = w_ld_in_range ? ST_SHIFT : ST_IDLE;
    else if (w_fire && w_last)    w_next_state = ST_IDLE;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= ST_IDLE;
    else         r_state <= w_next_state;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_data     <= '0;
      r_posx     <= '0;
      r_posy     <= '0;
      r_scale_m1 <= '0;
      r_pix_cnt  <= '0;
      r_rep_cnt  <= '0;
    end else if (w_ld_valid) begin
      r_data     <= w_ld_data;
      r_posx     <= w_ld_posx;
      r_posy     <= w_ld_posy;
      r_scale_m1 <= (w_ld_scale == '0) ? '0 : w_ld_scale - 1'b1;
      r_pix_cnt  <= '0;
      r_rep_cnt  <= '0;
    end else if (w_fire) begin
      r_posx <= r_posx + 1'b1;
      if (r_rep_cnt == r_scale_m1) begin
        r_rep_cnt <= '0;
        r_pix_cnt <= r_pix_cnt + 1'b1;
        r_data    <= r_data << PIX_BITS;
      end else begin
        r_rep_cnt <= r_rep_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_char_row_serializer.sv
// tb/tb_char_row_serializer.sv - directed bench with a beat-list reference model for char_row_serializer
module tb_char_row_serializer;

  localparam int PB = 2;
  localparam int NP = 9;
  localparam int SW = 1920;
  localparam int SH = 1080;
`ifdef ROW_PREFETCH_EN
  localparam int SPAN2 = 18;
`else
  localparam int SPAN2 = 19;
`endif

  typedef struct {
    int d;
    int x;
    int y;
    int last;
  } beat_t;

  logic              clk = 1'b0;
  logic              resetn = 1'b1;
  logic [2:0]        cfg_scale = 3'd1;
  logic [NP*PB-1:0]  s_data = '0;
  logic              s_valid = 1'b0;
  logic [10:0]       s_posx = '0;
  logic [10:0]       s_posy = '0;
  logic              s_ready;
  logic [PB-1:0]     m_data;
  logic              m_valid;
  logic              m_ready = 1'b1;
  logic [10:0]       m_posx;
  logic [10:0]       m_posy;
  logic              m_last;
  logic              busy;

  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    first_v = -1;
  int    last_v = -1;
  int    nvalid = 0;
  bit    rnd_ready = 1'b0;
  beat_t exp_q[$];
  beat_t seen[$];

  char_row_serializer #(.PIX_BITS(PB)) dut (
    .clk                (clk),
    .resetn             (resetn),
    .cfg_scale          (cfg_scale),
    .s_row_pixels_data  (s_data),
    .s_row_pixels_valid (s_valid),
    .s_row_pixels_posX  (s_posx),
    .s_row_pixels_posY  (s_posy),
    .s_row_pixels_ready (s_ready),
    .m_pixel_data       (m_data),
    .m_pixel_valid      (m_valid),
    .m_pixel_ready      (m_ready),
    .m_pixel_posX       (m_posx),
    .m_pixel_posY       (m_posy),
    .m_pixel_last       (m_last),
    .busy               (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", nm, got, want);
    end
  endtask

  // Reference: list every beat the row must produce, applying scale, clip and out-of-range rules
  task automatic model_row(input logic [NP*PB-1:0] d, input int x, input int y, input int sc);
    int s;
    int k;
    int n;
    beat_t b;
    s = (sc == 0) ? 1 : sc;
    k = 0;
    n = 0;
    if (x >= SW || y >= SH) return;
    for (int p = 0; p < NP; p++) begin
      for (int r = 0; r < s; r++) begin
        if (x + k <= SW - 1) begin
          b.d = int'(d[(NP-1-p)*PB +: PB]);
          b.x = x + k;
          b.y = y;
          b.last = 0;
          exp_q.push_back(b);
          n++;
        end
        k++;
      end
    end
    if (n > 0) exp_q[exp_q.size()-1].last = 1;
  endtask

  always @(negedge clk) begin
    cyc++;
    if (resetn) begin
      if (m_valid) begin
        if (first_v < 0) first_v = cyc;
        last_v = cyc;
        nvalid++;
        if (exp_q.size() == 0) begin
          chk("unexpected_beat_x", int'(m_posx), -1);
        end else begin
          chk("beat_data", int'(m_data), exp_q[0].d);
          chk("beat_posx", int'(m_posx), exp_q[0].x);
          chk("beat_posy", int'(m_posy), exp_q[0].y);
          chk("beat_last", int'(m_last), exp_q[0].last);
          if (m_ready) begin
            seen.push_back(exp_q[0]);
            void'(exp_q.pop_front());
          end
        end
      end
      if (s_valid && s_ready) model_row(s_data, int'(s_posx), int'(s_posy), int'(cfg_scale));
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      m_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  function automatic logic [NP*PB-1:0] widen(input logic [NP-1:0] b);
    logic [NP*PB-1:0] o;
    o = '0;
    for (int i = 0; i < NP; i++) o[i*PB] = b[i];
    return o;
  endfunction

  // Called at posedge+1; returns at posedge+1 just after the accepting edge
  task automatic send_row(input logic [NP*PB-1:0] d, input int x, input int y, input int sc);
    int n;
    s_data = d;
    s_posx = 11'(x);
    s_posy = 11'(y);
    cfg_scale = 3'(sc);
    s_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (s_ready) break;
      n++;
      if (n > 200) begin
        chk("accept_timeout", 0, 1);
        break;
      end
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      #1;
      if (exp_q.size() == 0 && !m_valid) break;
      n++;
      if (n > 500) begin
        chk("drain_timeout", 0, 1);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    seen.delete();
    first_v = -1;
    last_v = -1;
    nvalid = 0;
  endtask

  initial begin
    #1 resetn = 1'b0;
    #12;
    chk("rst_valid", int'(m_valid), 0);
    chk("rst_last", int'(m_last), 0);
    chk("rst_data", int'(m_data), 0);
    chk("rst_posx", int'(m_posx), 0);
    chk("rst_posy", int'(m_posy), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ready", int'(s_ready), 0);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_after_release", int'(s_ready), 1);

    // 1: scale 1
    clear_logs();
    send_row(widen(9'b101100001), 100, 20, 1);
    chk("t1_latency_valid", int'(m_valid), 1);
    drain();
    chk("t1_beats", seen.size(), 9);
    chk("t1_first_x", seen[0].x, 100);
    chk("t1_b1_data", seen[1].d, 0);
    chk("t1_b7_last", seen[7].last, 0);
    chk("t1_b8_x", seen[8].x, 108);
    chk("t1_b8_last", seen[8].last, 1);

    // 2: scale 3
    clear_logs();
    send_row(widen(9'b101100001), 100, 20, 3);
    drain();
    chk("t2_beats", seen.size(), 27);
    chk("t2_b2_data", seen[2].d, 1);
    chk("t2_b3_data", seen[3].d, 0);
    chk("t2_b26_x", seen[26].x, 126);
    chk("t2_b26_last", seen[26].last, 1);

    // 3: right clip
    clear_logs();
    send_row(widen(9'b111111111), 1915, 7, 1);
    drain();
    chk("t3_beats", seen.size(), 5);
    chk("t3_b4_x", seen[4].x, 1919);
    chk("t3_b4_last", seen[4].last, 1);
    chk("t3_idle_busy", int'(busy), 0);
    chk("t3_idle_ready", int'(s_ready), 1);

    // 4: out of range Y
    clear_logs();
    send_row(widen(9'b111111111), 10, 1080, 1);
    chk("t4_ready_next", int'(s_ready), 1);
    repeat (5) @(posedge clk);
    #1;
    chk("t4_no_beats", nvalid, 0);
    chk("t4_busy", int'(busy), 0);

    // 5: random downstream stalls, 2-bit pixels, scale 0 treated as 1 then scale 2
    clear_logs();
    rnd_ready = 1'b1;
    send_row(18'($urandom), 300, 5, 2);
    drain();
    chk("t5_beats", seen.size(), 18);
    clear_logs();
    send_row(18'($urandom), 400, 6, 0);
    drain();
    chk("t5_scale0_beats", seen.size(), 9);
    rnd_ready = 1'b0;
    @(posedge clk);
    #1;

    // 6: back-to-back rows
    clear_logs();
    send_row(widen(9'b101100001), 40, 30, 1);
    send_row(widen(9'b010011110), 49, 30, 1);
    drain();
    chk("t6_valid_beats", nvalid, 18);
    chk("t6_span", last_v - first_v + 1, SPAN2);
    chk("t6_b9_x", seen[9].x, 49);

    // 6b: reset mid-row
    clear_logs();
    send_row(widen(9'b110011001), 0, 0, 7);
    repeat (10) @(posedge clk);
    #2;
    resetn = 1'b0;
    exp_q.delete();
    #1;
    chk("rst_mid_valid", int'(m_valid), 0);
    chk("rst_mid_busy", int'(busy), 0);
    chk("rst_mid_ready", int'(s_ready), 0);
    @(negedge clk);
    resetn = 1'b1;
    clear_logs();
    @(posedge clk);
    #1;
    chk("rst_mid_ready_after", int'(s_ready), 1);
    repeat (10) @(posedge clk);
    #1;
    chk("rst_mid_no_residual", nvalid, 0);

    clear_logs();
    send_row(widen(9'b000000001), 1910, 1079, 2);
    drain();
    chk("post_rst_beats", seen.size(), 10);
    chk("post_rst_last_d", seen[9].d, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
